// File: rtl/attn_row_scheduler.sv
// Row sequencer for one attention_core: fetches K_TILE q/k/v elements per row,
// streams them into the core and writes each row's scaled result to the output buffer.
module attn_row_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int K_TILE     = 16,
  parameter int ADDR_W     = 10,
  parameter int ROWS_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_q_base,
  input  logic [ADDR_W-1:0]     cmd_kv_base,
  input  logic [ADDR_W-1:0]     cmd_out_base,
  input  logic [ROWS_W-1:0]     cmd_rows,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_q_addr,
  output logic [ADDR_W-1:0]     rd_kv_addr,
  input  logic [DATA_WIDTH-1:0] rd_q_data,
  input  logic [DATA_WIDTH-1:0] rd_k_data,
  input  logic [DATA_WIDTH-1:0] rd_v_data,
  output logic                  core_start,
  output logic                  core_in_valid,
  input  logic                  core_in_ready,
  output logic [DATA_WIDTH-1:0] core_q,
  output logic [DATA_WIDTH-1:0] core_k,
  output logic [DATA_WIDTH-1:0] core_v,
  input  logic                  core_out_valid,
  output logic                  core_out_ready,
  input  logic [DATA_WIDTH-1:0] core_out_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(K_TILE + 1);

  typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       q_base, kv_base, out_base, row_off;
  logic [ROWS_W-1:0]       rows, row;
  logic [CNT_W-1:0]        issued, consumed;
  logic [3*DATA_WIDTH-1:0] fifo0, fifo1;
  logic [1:0]              occ;
  logic                    rd_pending;
  logic                    pop;
  logic                    accept;
  logic [3*DATA_WIDTH-1:0] sram_word;

  // Handshakes: a transfer happens on any cycle with valid && ready; no valid depends on its ready.
  assign cmd_ready      = (state == IDLE);
  assign accept         = cmd_valid && cmd_ready;
  assign core_start     = (state == START);
  assign core_in_valid  = (state == STREAM) && (occ != 2'd0);
  assign core_out_ready = (state == DRAIN);
  assign {core_q, core_k, core_v} = fifo0;
  assign pop            = core_in_valid && core_in_ready;
  assign sram_word      = {rd_q_data, rd_k_data, rd_v_data};

  // The slot freed by this cycle's pop is credited so one read per cycle sustains full rate.
  assign rd_en = ((state == START) || (state == STREAM)) &&
                 (issued < CNT_W'(K_TILE)) &&
                 (({1'b0, occ} - {2'b00, pop} + {2'b00, rd_pending}) < 3'd2);

  assign rd_q_addr  = q_base + row_off + ADDR_W'(issued);
  assign rd_kv_addr = kv_base + row_off + ADDR_W'(issued);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      q_base     <= '0;
      kv_base    <= '0;
      out_base   <= '0;
      rows       <= '0;
      row        <= '0;
      row_off    <= '0;
      issued     <= '0;
      consumed   <= '0;
      fifo0      <= '0;
      fifo1      <= '0;
      occ        <= '0;
      rd_pending <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      done       <= 1'b0;
      rd_pending <= rd_en;
      if (done) busy <= 1'b0;
      if (rd_en) issued <= issued + CNT_W'(1);
      if (pop) consumed <= consumed + CNT_W'(1);

      case ({rd_pending, pop})
        2'b10: begin
          if (occ == 2'd0) fifo0 <= sram_word;
          else             fifo1 <= sram_word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          fifo0 <= fifo1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            fifo0 <= sram_word;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= sram_word;
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (accept) begin
            q_base   <= cmd_q_base;
            kv_base  <= cmd_kv_base;
            out_base <= cmd_out_base;
            rows     <= cmd_rows;
            row      <= '0;
            row_off  <= '0;
            issued   <= '0;
            consumed <= '0;
            if (cmd_rows == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= START;
            end
          end
        end
        START: state <= STREAM;
        STREAM: begin
          if (pop && (consumed == CNT_W'(K_TILE - 1))) state <= DRAIN;
        end
        DRAIN: begin
          if (core_out_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= out_base + ADDR_W'(row);
            wr_data <= core_out_data;
            if (row == rows - ROWS_W'(1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              row      <= row + ROWS_W'(1);
              row_off  <= row_off + ADDR_W'(K_TILE);
              issued   <= '0;
              consumed <= '0;
              state    <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_row_scheduler.sv
// Bench for attn_row_scheduler: SRAM and core models, a spec-level reference that
// plans reads/elements/writes per job, and a negedge monitor scoring against it.
module tb_attn_row_scheduler;

  localparam int DW = 16;
  localparam int KT = 16;
  localparam int AW = 10;
  localparam int RW = 8;
  localparam int LIMIT = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_q_base = '0;
  logic [AW-1:0] cmd_kv_base = '0;
  logic [AW-1:0] cmd_out_base = '0;
  logic [RW-1:0] cmd_rows = '0;
  logic          rd_en;
  logic [AW-1:0] rd_q_addr, rd_kv_addr;
  logic [DW-1:0] rd_q_data, rd_k_data, rd_v_data;
  logic          core_start, core_in_valid, core_in_ready;
  logic [DW-1:0] core_q, core_k, core_v;
  logic          core_out_valid, core_out_ready;
  logic [DW-1:0] core_out_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] q_mem [1<<AW];
  logic [DW-1:0] k_mem [1<<AW];
  logic [DW-1:0] v_mem [1<<AW];

  logic [2*AW-1:0] exp_rd_q [$];
  logic [3*DW-1:0] exp_el_q [$];
  logic [AW+DW:0]  exp_wr_q [$];

  int ready_mode = 0;
  bit timing_chk = 1'b1;
  int rd_cnt = 0, pop_cnt = 0, start_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int job_starts = 0, first_start = 0, row_start = 0, last_done = 0, beat = 0;

  logic [47:0] core_acc;
  int          core_cnt;

  attn_row_scheduler #(.DATA_WIDTH(DW), .K_TILE(KT), .ADDR_W(AW), .ROWS_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_q_base(cmd_q_base), .cmd_kv_base(cmd_kv_base),
    .cmd_out_base(cmd_out_base), .cmd_rows(cmd_rows),
    .rd_en(rd_en), .rd_q_addr(rd_q_addr), .rd_kv_addr(rd_kv_addr),
    .rd_q_data(rd_q_data), .rd_k_data(rd_k_data), .rd_v_data(rd_v_data),
    .core_start(core_start), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_q(core_q), .core_k(core_k), .core_v(core_v),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .core_out_data(core_out_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM model: data valid exactly one cycle after rd_en, garbage otherwise
  always @(posedge clk) begin
    if (rd_en) begin
      rd_q_data <= q_mem[rd_q_addr];
      rd_k_data <= k_mem[rd_kv_addr];
      rd_v_data <= v_mem[rd_kv_addr];
    end else begin
      rd_q_data <= DW'($urandom);
      rd_k_data <= DW'($urandom);
      rd_v_data <= DW'($urandom);
    end
  end

  // core model: sums q*k*v over K_TILE accepted elements, result is the sum >> 8
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt       <= 0;
      core_acc       <= '0;
      core_out_valid <= 1'b0;
      core_out_data  <= '0;
      core_in_ready  <= 1'b1;
    end else begin
      case (ready_mode)
        0:       core_in_ready <= 1'b1;
        1:       core_in_ready <= ~core_in_ready;
        default: core_in_ready <= 1'($urandom_range(0, 1));
      endcase
      if (core_start) begin
        core_cnt <= 0;
        core_acc <= '0;
      end else if (core_in_valid && core_in_ready) begin
        core_acc <= core_acc + core_q * core_k * core_v;
        core_cnt <= core_cnt + 1;
        if (core_cnt == KT - 1) begin
          core_out_valid <= 1'b1;
          core_out_data  <= DW'((core_acc + core_q * core_k * core_v) >> 8);
        end
      end
      if (core_out_valid && core_out_ready) core_out_valid <= 1'b0;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_cnt++;
        if (timing_chk) chk("wr_cycle", cyc - row_start, KT + 3);
        chk("wr_busy", busy, 1'b1);
        chk("wr_expected", exp_wr_q.size() != 0, 1'b1);
        if (exp_wr_q.size() != 0) chk("wr_done_addr_data", {done, wr_addr, wr_data}, exp_wr_q.pop_front());
      end
      if (core_start) begin
        start_cnt++;
        if (job_starts == 0) first_start = cyc;
        else if (timing_chk) chk("start_spacing", cyc - row_start, KT + 3);
        job_starts++;
        row_start = cyc;
        beat = 0;
      end
      if (core_in_valid && core_in_ready) begin
        pop_cnt++;
        if (timing_chk) chk("beat_cycle", cyc, row_start + 2 + beat);
        beat++;
        chk("el_expected", exp_el_q.size() != 0, 1'b1);
        if (exp_el_q.size() != 0) chk("el_order", {core_q, core_k, core_v}, exp_el_q.pop_front());
      end
      if (rd_en) begin
        rd_cnt++;
        chk("fifo_depth", (rd_cnt - pop_cnt) <= 2, 1'b1);
        chk("rd_expected", exp_rd_q.size() != 0, 1'b1);
        if (exp_rd_q.size() != 0) chk("rd_addr", {rd_q_addr, rd_kv_addr}, exp_rd_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        last_done = cyc;
      end
    end
  end

  // reference model: every read, element and write a job must produce
  task automatic plan_job(input logic [AW-1:0] qb, input logic [AW-1:0] kvb,
                          input logic [AW-1:0] ob, input logic [RW-1:0] rows);
    logic [AW-1:0] qa, ka;
    logic [47:0]   acc;
    for (int r = 0; r < int'(rows); r++) begin
      acc = '0;
      for (int k = 0; k < KT; k++) begin
        qa = AW'(int'(qb) + r * KT + k);
        ka = AW'(int'(kvb) + r * KT + k);
        exp_rd_q.push_back({qa, ka});
        exp_el_q.push_back({q_mem[qa], k_mem[ka], v_mem[ka]});
        acc = acc + q_mem[qa] * k_mem[ka] * v_mem[ka];
      end
      exp_wr_q.push_back({(r == int'(rows) - 1), AW'(int'(ob) + r), DW'(acc >> 8)});
    end
  endtask

  // driver tasks
  task automatic send_cmd(input logic [AW-1:0] qb, input logic [AW-1:0] kvb,
                          input logic [AW-1:0] ob, input logic [RW-1:0] rows, output int acc);
    int n;
    n = 0;
    cmd_q_base = qb; cmd_kv_base = kvb; cmd_out_base = ob; cmd_rows = rows;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_timeout", done_cnt != d0, 1'b1);
  endtask

  task automatic run_job(input logic [AW-1:0] qb, input logic [AW-1:0] kvb,
                         input logic [AW-1:0] ob, input logic [RW-1:0] rows);
    int acc, d0, s0, r0, w0;
    job_starts = 0;
    d0 = done_cnt; s0 = start_cnt; r0 = rd_cnt; w0 = wr_cnt;
    plan_job(qb, kvb, ob, rows);
    send_cmd(qb, kvb, ob, rows, acc);
    wait_done(d0);
    chk("done_count", done_cnt - d0, 1);
    if (rows == '0) begin
      chk("zero_done_cycle", last_done, acc);
      chk("zero_no_start", start_cnt - s0, 0);
      chk("zero_no_rd", rd_cnt - r0, 0);
      chk("zero_no_wr", wr_cnt - w0, 0);
    end else begin
      chk("first_start", first_start, acc);
      chk("start_count", start_cnt - s0, rows);
      chk("wr_count", wr_cnt - w0, rows);
      if (timing_chk) chk("done_cycle", last_done, first_start + int'(rows) * (KT + 3));
    end
    chk("busy_clear", busy, 1'b0);
    chk("queues_empty", exp_rd_q.size() + exp_el_q.size() + exp_wr_q.size(), 0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < (1 << AW); a++) begin
      q_mem[a] = DW'($urandom);
      k_mem[a] = DW'($urandom);
      v_mem[a] = DW'($urandom);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_strobes"}, {rd_en, core_start, core_in_valid, core_out_ready, wr_en, done, busy}, 7'd0);
    chk({tag, "_addr_data"}, {rd_q_addr, rd_kv_addr, wr_addr, wr_data, core_q, core_k, core_v}, '0);
  endtask

  initial begin : main
    int acc_a, d0, n, w0;
    logic [AW-1:0] qb, kvb, ob;
    fill_random();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single row, all ones: result 16 >> 8 = 0 at address 5
    for (int a = 0; a < (1 << AW); a++) begin
      q_mem[a] = 16'd1; k_mem[a] = 16'd1; v_mem[a] = 16'd1;
    end
    ready_mode = 0; timing_chk = 1'b1;
    run_job(10'd0, 10'd0, 10'd5, 8'd1);

    // three rows, q=k=16, v=r+1: results 16, 32, 48
    for (int a = 0; a < (1 << AW); a++) begin
      q_mem[a] = 16'd16; k_mem[a] = 16'd16;
    end
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < KT; k++) v_mem[100 + r * KT + k] = DW'(r + 1);
    run_job(10'd0, 10'd100, 10'd40, 8'd3);

    // backpressure: toggling ready, then random ready
    fill_random();
    ready_mode = 1; timing_chk = 1'b0;
    run_job(10'd32, 10'd512, 10'd7, 8'd2);
    ready_mode = 2;
    run_job(10'd200, 10'd300, 10'd9, 8'd2);

    // address wrap on reads and writes
    ready_mode = 0; timing_chk = 1'b1;
    run_job(10'd1020, 10'd1010, 10'd1023, 8'd2);

    // zero-row job
    run_job(10'd3, 10'd4, 10'd5, 8'd0);

    // command presented while busy waits for cmd_ready
    timing_chk = 1'b0;
    d0 = done_cnt;
    plan_job(10'd64, 10'd128, 10'd20, 8'd2);
    send_cmd(10'd64, 10'd128, 10'd20, 8'd2, acc_a);
    plan_job(10'd600, 10'd700, 10'd30, 8'd1);
    cmd_q_base = 10'd600; cmd_kv_base = 10'd700; cmd_out_base = 10'd30; cmd_rows = 8'd1;
    cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_cmd_ready", cmd_ready, 1'b0);
    chk("busy_high", busy, 1'b1);
    wait_done(d0);
    cmd_valid = 1'b0;
    job_starts = 0;
    chk("second_busy", busy, 1'b1);
    d0 = done_cnt;
    wait_done(d0);
    chk("second_start", first_start, last_done - (KT + 3));
    chk("busy_queues_empty", exp_rd_q.size() + exp_el_q.size() + exp_wr_q.size(), 0);

    // random jobs against the reference
    for (int j = 0; j < 4; j++) begin
      fill_random();
      ready_mode = $urandom_range(0, 2);
      timing_chk = (ready_mode == 0);
      qb = AW'($urandom); kvb = AW'($urandom); ob = AW'($urandom);
      run_job(qb, kvb, ob, RW'($urandom_range(1, 3)));
    end

    // reset in row 1 of 3 abandons the job
    ready_mode = 0; timing_chk = 1'b0;
    fill_random();
    job_starts = 0;
    plan_job(10'd0, 10'd200, 10'd300, 8'd3);
    send_cmd(10'd0, 10'd200, 10'd300, 8'd3, acc_a);
    repeat (KT + 3 + 6) @(posedge clk);
    #2;
    chk("mid_reset_streaming", core_in_valid, 1'b1);
    rst_n = 1'b0;
    exp_rd_q.delete(); exp_el_q.delete(); exp_wr_q.delete();
    #1;
    check_quiet("mid_reset");
    rd_cnt = 0; pop_cnt = 0;
    w0 = wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_cmd_ready", cmd_ready, 1'b1);
    n = 0;
    while (n < 3 * (KT + 3)) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("post_reset_no_wr", wr_cnt - w0, 0);
    chk("post_reset_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/attn_row_scheduler.md
Name: attn_row_scheduler

Overview:
- Sequences one attention_core instance across a multi-row job.
- For each row, fetches K_TILE q/k/v elements from two on-chip SRAMs, streams them into the core, and collects the single scaled result.
- Writes each result to the output buffer.
- Sits between the command/descriptor logic and the core; it is the only driver of the core's start and input stream.

Parameters:
- DATA_WIDTH, 16, element and result width; must match the core.
- K_TILE, 16, elements per row; must match the core; must be ≥ 2.
- ADDR_W, 10, SRAM and output-buffer address width.
- ROWS_W, 8, width of the row-count field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  job descriptor valid
- cmd_ready  out  1  scheduler can accept a job
- cmd_q_base  in  ADDR_W  Q SRAM base address
- cmd_kv_base  in  ADDR_W  KV SRAM base address
- cmd_out_base  in  ADDR_W  output buffer base address
- cmd_rows  in  ROWS_W  number of rows in the job
- rd_en  out  1  SRAM read strobe (Q and KV read together)
- rd_q_addr  out  ADDR_W  Q SRAM address
- rd_kv_addr  out  ADDR_W  KV SRAM address (K and V share it)
- rd_q_data, rd_k_data, rd_v_data  in  DATA_WIDTH each  SRAM data, valid exactly 1 cycle after rd_en
- core_start  out  1  one-cycle start pulse to the core
- core_in_valid  out  1  element valid to the core
- core_in_ready  in  1  core accepts element
- core_q, core_k, core_v  out  DATA_WIDTH each  element data
- core_out_valid  in  1  core result valid
- core_out_ready  out  1  scheduler accepts result
- core_out_data  in  DATA_WIDTH  core result
- wr_en  out  1  output buffer write, always accepted
- wr_addr  out  ADDR_W  output buffer address
- wr_data  out  DATA_WIDTH  output buffer data
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values:
  - State IDLE.
  - All strobes (rd_en, core_start, core_in_valid, core_out_ready, wr_en, done, busy) are 0.
  - Addresses, data, counters, and buffer occupancy are 0.
- Reset mid-job: abandons the job with no further writes. The core is reset by the same rst_n.
- States: IDLE, START, STREAM, DRAIN.
- cmd_ready = (state==IDLE). A job is accepted when cmd_valid && cmd_ready; all cmd_* fields are latched at acceptance.
- Zero-row job: cmd_rows==0 is accepted, done pulses the next cycle, there is no SRAM, core, or write activity, and state stays IDLE.
- Nonzero job: IDLE → START; row counter r=0; busy=1 from the cycle after acceptance until the cycle after done.
- START (1 cycle):
  - core_start=1.
  - Element issue counter and consume counter clear to 0.
  - The first read (k=0) is issued this cycle.
  - → STREAM.
- Read addressing (modulo 2^ADDR_W):
  - rd_q_addr = q_base + r*K_TILE + k.
  - rd_kv_addr = kv_base + r*K_TILE + k.
- Prefetch:
  - A 2-entry FIFO holds {q,k,v}; SRAM data is captured the cycle after rd_en.
  - rd_en is asserted in START/STREAM when issued < K_TILE and (occupancy + reads in flight) < 2.
  - The FIFO never overflows. No bypass: SRAM data always lands in the FIFO first.
- STREAM:
  - core_in_valid = FIFO non-empty; core_q/k/v = FIFO head.
  - Pop on core_in_valid && core_in_ready.
  - core_in_ready low stalls without data loss, and reads pause per the prefetch rule.
  - After the K_TILE-th pop → DRAIN.
- DRAIN:
  - core_out_ready=1.
  - On core_out_valid fire, register wr_en=1, wr_addr = out_base + r (mod 2^ADDR_W), wr_data = core_out_data; wr_en is high for one cycle, the cycle after the fire.
  - If r == rows−1: → IDLE, with done=1 in the same cycle as that final wr_en.
  - Otherwise: r++, → START, in the same cycle as wr_en.
- Unstalled row period: K_TILE+3 cycles.
  - START at cycle 0; first element at cycle 2; last element at K_TILE+1.
  - Result fire at K_TILE+2; wr_en at K_TILE+3, which is also the next row's START.
  - core_start is therefore never asserted while the core is outside its idle state.
- cmd_valid while busy is ignored, because cmd_ready=0.

Test Plan:
- Reset check: mid-STREAM reset (row 1 of 3) → all outputs 0 immediately, cmd_ready=1 after release, no further wr_en.
- Single row: K_TILE=16, q=k=v=1 (every element), q_base=0, kv_base=0, out_base=5, rows=1 → core_start at cycle 1 after accept; 16 consecutive core_in_valid beats; wr_en with wr_addr=5, wr_data=0 (sum 16, shifted by 8); done with that wr_en; total 19 cycles from START.
- Multi-row with distinct results: rows=3, each row uses q=16, k=16, v=r+1 → wr_data 16, 32, 48 at addresses out_base+0..2; consecutive START pulses 19 cycles apart; exactly one done.
- Backpressure: core_in_ready toggled 1-0-1-0 (bench core model) → FIFO never exceeds 2 entries; element order q[0..15] preserved; no duplicated or dropped beats; same result as unstalled.
- Address wrap: ADDR_W=10, q_base=1020, rows=1 → reads 1020..1023 then 0..11; out_base=1023, rows=2 → writes to 1023 then 0.
- Zero rows and busy-command: cmd_rows=0 → done next cycle, no rd_en, core_start, or wr_en; a second cmd_valid during a busy job → not accepted until cmd_ready returns.
